cache_refill_controller: RTL

Miss-side partner of the cache replacement controller. On a miss it consumes the one-hot victim way chosen by replacement and writes the victim line back to memory if it is dirty. It then fetches the missing line word-by-word over a req/ready memory handshake, fills the victim way, and commits tag/valid. It sits between the cache data/tag arrays and the memory port, and signals completion to the cache FSM.

---
 rtl/cache_refill_controller_pkg.sv | 14 +
 rtl/cache_refill_controller.sv | 136 +++++++++++++
 2 files changed

// File: rtl/cache_refill_controller_pkg.sv
// Shared types and defaults for the cache refill controller.
// The refill FSM state encoding and the default way count live here.
package cache_refill_controller_pkg;

  localparam int CACHE_E = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB     = 2'd1,
    FILL   = 2'd2,
    COMMIT = 2'd3
  } refill_state_e;

endpackage

// File: rtl/cache_refill_controller.sv
// Miss-side refill engine: optional dirty write-back of the victim line,
// word-by-word line fetch into the victim way, then a one-cycle tag commit.
module cache_refill_controller
  import cache_refill_controller_pkg::*;
#(
  parameter int SET_SIZE     = CACHE_E,
  parameter int LINE_WORDS   = 4,
  parameter int INDEX_WIDTH  = 4,
  parameter int OFFSET_WIDTH = $clog2(LINE_WORDS) + 2,
  parameter int TAG_WIDTH    = 32 - INDEX_WIDTH - OFFSET_WIDTH
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          miss_i,
  input  logic [31:0]                   addr_i,
  input  logic [SET_SIZE-1:0]           victim_line_i,
  input  logic                          victim_dirty_i,
  input  logic [TAG_WIDTH-1:0]          victim_tag_i,
  input  logic [31:0]                   line_rdata_i,
  output logic [SET_SIZE-1:0]           line_sel_o,
  output logic [$clog2(LINE_WORDS)-1:0] line_word_o,
  output logic                          line_we_o,
  output logic [31:0]                   line_wdata_o,
  output logic                          tag_we_o,
  output logic [TAG_WIDTH-1:0]          tag_o,
  output logic                          mem_req_o,
  output logic                          mem_we_o,
  output logic [31:0]                   mem_addr_o,
  output logic [31:0]                   mem_wdata_o,
  input  logic                          mem_ready_i,
  input  logic [31:0]                   mem_rdata_i,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);

  // Memory handshake: a word transfers on any cycle with mem_req_o & mem_ready_i;
  // address, direction and write data stay fixed until that cycle.
  refill_state_e              state_q, state_d;
  logic [WORD_W-1:0]          cnt_q, cnt_d;
  logic [INDEX_WIDTH-1:0]     index_q, index_d;
  logic [TAG_WIDTH-1:0]       fill_tag_q, fill_tag_d;
  logic [TAG_WIDTH-1:0]       vtag_q, vtag_d;
  logic [SET_SIZE-1:0]        victim_q, victim_d;

  // Byte-offset bits of the miss address never matter: refills are whole lines.
  logic unused_offset;
  assign unused_offset = ^addr_i[OFFSET_WIDTH-1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      index_q    <= '0;
      fill_tag_q <= '0;
      vtag_q     <= '0;
      victim_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      index_q    <= index_d;
      fill_tag_q <= fill_tag_d;
      vtag_q     <= vtag_d;
      victim_q   <= victim_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    index_d      = index_q;
    fill_tag_d   = fill_tag_q;
    vtag_d       = vtag_q;
    victim_d     = victim_q;
    line_sel_o   = '0;
    line_word_o  = '0;
    line_we_o    = 1'b0;
    line_wdata_o = '0;
    tag_we_o     = 1'b0;
    tag_o        = '0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    busy_o       = (state_q != IDLE);
    done_o       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (miss_i) begin
          index_d    = addr_i[OFFSET_WIDTH +: INDEX_WIDTH];
          fill_tag_d = addr_i[31 -: TAG_WIDTH];
          vtag_d     = victim_tag_i;
          victim_d   = victim_line_i;
          cnt_d      = '0;
          state_d    = victim_dirty_i ? WB : FILL;
        end
      end
      WB: begin
        line_sel_o  = victim_q;
        line_word_o = cnt_q;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {vtag_q, index_q, cnt_q, 2'b00};
        mem_wdata_o = line_rdata_i;
        if (mem_ready_i) begin
          cnt_d = cnt_q + WORD_W'(1);
          if (cnt_q == LAST_WORD) state_d = FILL;
        end
      end
      FILL: begin
        line_sel_o   = victim_q;
        line_word_o  = cnt_q;
        line_we_o    = mem_ready_i;
        line_wdata_o = mem_rdata_i;
        mem_req_o    = 1'b1;
        mem_addr_o   = {fill_tag_q, index_q, cnt_q, 2'b00};
        if (mem_ready_i) begin
          cnt_d = cnt_q + WORD_W'(1);
          if (cnt_q == LAST_WORD) state_d = COMMIT;
        end
      end
      COMMIT: begin
        line_sel_o = victim_q;
        tag_we_o   = 1'b1;
        tag_o      = fill_tag_q;
        done_o     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
